// File: rtl/sd_spi_arbiter.sv
// ---------------------------------------------------------------------------
// sd_spi_arbiter
//
// Shares a single sdspihost SPI engine between two requesters. Requester 0
// is the autotest FSM and requester 1 is the second client. A four-state FSM
// (IDLE, GRANT_0, GRANT_1, RELEASE) owns the engine. Only the requester that
// holds the grant can reach the host. A requester that keeps its request up
// but stays idle for too long loses the grant through a hold-timeout.
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   req_i / gnt_i                 per-requester bus request / registered grant
//   r_block_i .. spi_rst_i        per-requester SPI command strobes
//   block_addr_i, data_in_i       per-requester block address / write byte
//   busy_i, data_out_i,
//   err_i, crc_err_i              per-requester return path
//   timeout_i                     sticky flag: grant revoked by hold-timeout
//   spi_*  (outputs)              commands, address and write data to the host
//   spi_busy, spi_err,
//   spi_crc_err, spi_data_out     status and read data from the host
// ---------------------------------------------------------------------------
module sd_spi_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h6E00000
) (
  input  logic        clk,
  input  logic        rst,

  // requester 0 (autotest FSM)
  input  logic        req_0,
  output logic        gnt_0,
  input  logic        r_block_0,
  input  logic        r_byte_0,
  input  logic        r_multi_block_0,
  input  logic        w_block_0,
  input  logic        w_byte_0,
  input  logic        spi_rst_0,
  input  logic [31:0] block_addr_0,
  input  logic [7:0]  data_in_0,
  output logic        busy_0,
  output logic [7:0]  data_out_0,
  output logic        err_0,
  output logic        crc_err_0,
  output logic        timeout_0,

  // requester 1
  input  logic        req_1,
  output logic        gnt_1,
  input  logic        r_block_1,
  input  logic        r_byte_1,
  input  logic        r_multi_block_1,
  input  logic        w_block_1,
  input  logic        w_byte_1,
  input  logic        spi_rst_1,
  input  logic [31:0] block_addr_1,
  input  logic [7:0]  data_in_1,
  output logic        busy_1,
  output logic [7:0]  data_out_1,
  output logic        err_1,
  output logic        crc_err_1,
  output logic        timeout_1,

  // to sdspihost
  output logic        spi_r_block,
  output logic        spi_r_byte,
  output logic        spi_r_multi_block,
  output logic        spi_w_block,
  output logic        spi_w_byte,
  output logic        spi_rst,
  output logic [31:0] spi_block_addr,
  output logic [7:0]  spi_data_in,

  // from sdspihost
  input  logic        spi_busy,
  input  logic        spi_err,
  input  logic        spi_crc_err,
  input  logic [7:0]  spi_data_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_0 = 2'd1,
    GRANT_1 = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [31:0] HOLD_LIMIT = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] HOLD_MAX   = 32'hFFFF_FFFF;

  state_t      state_reg, state_next;
  logic        last_served_reg, last_served_next;
  logic [31:0] hold_cnt_reg, hold_cnt_next;
  logic [1:0]  timeout_reg, timeout_next;

  // -------------------------------------------------------------------------
  // Requester-side signals gathered into vectors so that the arbitration and
  // the return path can be indexed by requester number.
  // Command bundle bit order: {spi_rst, w_byte, w_block, r_multi, r_byte, r_block}
  // -------------------------------------------------------------------------
  logic [1:0]  req_vec;
  logic [1:0]  gnt_vec;
  logic [5:0]  cmd_vec  [2];
  logic [31:0] addr_vec [2];
  logic [7:0]  din_vec  [2];
  logic [1:0]  busy_vec;
  logic [1:0]  err_vec;
  logic [1:0]  crc_err_vec;
  logic [7:0]  dout_vec [2];

  assign req_vec     = {req_1, req_0};
  assign cmd_vec[0]  = {spi_rst_0, w_byte_0, w_block_0, r_multi_block_0, r_byte_0, r_block_0};
  assign cmd_vec[1]  = {spi_rst_1, w_byte_1, w_block_1, r_multi_block_1, r_byte_1, r_block_1};
  assign addr_vec[0] = block_addr_0;
  assign addr_vec[1] = block_addr_1;
  assign din_vec[0]  = data_in_0;
  assign din_vec[1]  = data_in_1;

  // Grants are decoded straight from the state flop. This keeps them
  // glitch-free and lets the asynchronous reset drop them at once.
  assign gnt_vec[0] = (state_reg == GRANT_0);
  assign gnt_vec[1] = (state_reg == GRANT_1);

  // Per-requester return path. A requester without the grant sees a busy
  // host with neutral data. Any command it issues then simply waits.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_return
      assign busy_vec[gi]    = gnt_vec[gi] ? spi_busy     : 1'b1;
      assign dout_vec[gi]    = gnt_vec[gi] ? spi_data_out : 8'h00;
      assign err_vec[gi]     = gnt_vec[gi] ? spi_err      : 1'b0;
      assign crc_err_vec[gi] = gnt_vec[gi] ? spi_crc_err  : 1'b0;
    end
  endgenerate

  assign gnt_0      = gnt_vec[0];
  assign gnt_1      = gnt_vec[1];
  assign busy_0     = busy_vec[0];
  assign busy_1     = busy_vec[1];
  assign data_out_0 = dout_vec[0];
  assign data_out_1 = dout_vec[1];
  assign err_0      = err_vec[0];
  assign err_1      = err_vec[1];
  assign crc_err_0  = crc_err_vec[0];
  assign crc_err_1  = crc_err_vec[1];
  assign timeout_0  = timeout_reg[0];
  assign timeout_1  = timeout_reg[1];

  // -------------------------------------------------------------------------
  // Host-side mux. Only the granted requester reaches the host. In IDLE,
  // RELEASE and reset the host sees no command, address 0 and an all-ones
  // write byte, which is the idle level of the SPI MOSI line.
  // -------------------------------------------------------------------------
  logic [5:0] spi_cmd;

  always_comb begin
    spi_cmd        = 6'b0;
    spi_block_addr = 32'h0;
    spi_data_in    = 8'hFF;
    if (gnt_vec[0]) begin
      spi_cmd        = cmd_vec[0];
      spi_block_addr = addr_vec[0];
      spi_data_in    = din_vec[0];
    end else if (gnt_vec[1]) begin
      spi_cmd        = cmd_vec[1];
      spi_block_addr = addr_vec[1];
      spi_data_in    = din_vec[1];
    end
  end

  assign spi_r_block       = spi_cmd[0];
  assign spi_r_byte        = spi_cmd[1];
  assign spi_r_multi_block = spi_cmd[2];
  assign spi_w_block       = spi_cmd[3];
  assign spi_w_byte        = spi_cmd[4];
  assign spi_rst           = spi_cmd[5];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic owner;   // requester number that owns the current grant

  assign owner = (state_reg == GRANT_1);

  always_comb begin
    state_next       = state_reg;
    last_served_next = last_served_reg;
    hold_cnt_next    = hold_cnt_reg;
    timeout_next     = timeout_reg;

    case (state_reg)
      IDLE: begin
        hold_cnt_next = 32'h0;
        // Both requesting: the one that was not served last wins. The reset
        // value of last_served (1) gives requester 0 the first contention.
        if (req_vec[0] && (!req_vec[1] || last_served_reg)) begin
          state_next       = GRANT_0;
          last_served_next = 1'b0;
          timeout_next[0]  = 1'b0;
        end else if (req_vec[1]) begin
          state_next       = GRANT_1;
          last_served_next = 1'b1;
          timeout_next[1]  = 1'b0;
        end
      end

      GRANT_0, GRANT_1: begin
        if (!req_vec[owner]) begin
          // Voluntary release. Wait out a running host operation first so
          // that the next owner never sees a transfer it did not start.
          hold_cnt_next = 32'h0;
          state_next    = spi_busy ? RELEASE : IDLE;
        end else if (hold_cnt_reg == HOLD_LIMIT) begin
          // Owner kept req up but has been idle too long: revoke. Marking
          // it last served lets a waiting peer win the next arbitration.
          hold_cnt_next       = 32'h0;
          timeout_next[owner] = 1'b1;
          last_served_next    = owner;
          state_next          = RELEASE;
        end else if (spi_busy || (|cmd_vec[owner])) begin
          hold_cnt_next = 32'h0;
        end else if (hold_cnt_reg != HOLD_MAX) begin
          hold_cnt_next = hold_cnt_reg + 32'd1;
        end
      end

      RELEASE: begin
        hold_cnt_next = 32'h0;
        if (!spi_busy) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next    = IDLE;
        hold_cnt_next = 32'h0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      last_served_reg <= 1'b1;
      hold_cnt_reg    <= 32'h0;
      timeout_reg     <= 2'b00;
    end else begin
      state_reg       <= state_next;
      last_served_reg <= last_served_next;
      hold_cnt_reg    <= hold_cnt_next;
      timeout_reg     <= timeout_next;
    end
  end

endmodule
